fifo_wr_arbiter: RTL

- Write-side scheduler for the dual-clock async FIFO. Lives entirely in the wclk domain, in front of the write-pointer/full-flag block.
- Shares the single FIFO write port among NREQ requesters using round-robin arbitration with burst locking.
- Drives winc/wdata toward the FIFO and back-pressures every requester on wfull.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 91 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state type, stats width and default sizing for the async FIFO write side
package fifo_pkg;
    typedef enum logic {IDLE, LOCK} state_t;
    localparam int STAT_W = 16;
    localparam int DEF_NREQ = 4;
    localparam int DEF_DSIZE = 8;
    localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake and FIFO write-port bus around the write arbiter
interface fifo_wr_arbiter_if #(
    parameter int NREQ = fifo_pkg::DEF_NREQ,
    parameter int DSIZE = fifo_pkg::DEF_DSIZE,
    parameter int IDXW = $clog2(NREQ)
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ready;
    logic wfull;
    logic winc;
    logic [DSIZE-1:0] wdata;
    logic [IDXW-1:0] wsel;
    logic busy;
    modport master (
        output req_valid, req_data, req_last, wfull,
        input req_ready, winc, wdata, wsel, busy
    );
    modport slave (
        input req_valid, req_data, req_last, wfull,
        output req_ready, winc, wdata, wsel, busy
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder starting at ptr, one-hot grant plus index
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input logic [NREQ-1:0] valid,
    input logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] idx,
    output logic any
);
    logic [IDXW-1:0] j;
    // scan from farthest to nearest so the first valid at or after ptr overwrites the rest
    always_comb begin
        gnt = '0;
        idx = '0;
        j = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IDXW'((int'(ptr) + k) % NREQ);
            if (valid[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = j;
            end
        end
    end
    assign any = |valid;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking scheduler sharing the async FIFO write port.
// Define FIFO_WARB_STATS_EN to add per-requester beat counters and a full-stall counter.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DSIZE = DEF_DSIZE,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int IDXW = $clog2(NREQ)
) (
    input logic wclk,
    input logic wrst_n,
    fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_cnt,
    output logic [STAT_W-1:0] stat_stall
`endif
);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t state;
    logic [IDXW-1:0] rr_ptr, lock_idx, pick_idx, g;
    logic [BW-1:0] beat_cnt;
    logic [NREQ-1:0] pick_gnt;
    logic any_valid, ready_ok, winc, last_slot;

    function automatic logic [IDXW-1:0] inc_idx(input logic [IDXW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .valid(bus.req_valid),
        .ptr(rr_ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(any_valid)
    );

    assign g = (state == LOCK) ? lock_idx : pick_idx;
    assign ready_ok = wrst_n && !bus.wfull && (state == LOCK || any_valid);
    assign winc = ready_ok && bus.req_valid[g];
    assign last_slot = int'(beat_cnt) + 1 >= MAX_BURST;
    assign bus.req_ready = !ready_ok ? '0 : (state == LOCK) ? NREQ'(1) << lock_idx : pick_gnt;
    assign bus.winc = winc;
    assign bus.wdata = bus.req_data[g*DSIZE +: DSIZE];
    assign bus.wsel = wrst_n ? g : '0;
    assign bus.busy = state == LOCK;

    // grant lock and round-robin pointer only move on an accepted beat
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            lock_idx <= '0;
            beat_cnt <= '0;
        end else if (winc) begin
            if (state == IDLE) begin
                if (!bus.req_last[g] && MAX_BURST > 1) begin
                    state <= LOCK;
                    lock_idx <= g;
                    beat_cnt <= BW'(1);
                end else begin
                    rr_ptr <= inc_idx(g);
                end
            end else if (bus.req_last[g] || last_slot) begin
                state <= IDLE;
                rr_ptr <= inc_idx(lock_idx);
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`ifdef FIFO_WARB_STATS_EN
    // saturating per-requester beat counts and count of cycles stalled by a full FIFO
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stat_cnt <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (winc && int'(g) == i && stat_cnt[i*STAT_W +: STAT_W] != '1)
                    stat_cnt[i*STAT_W +: STAT_W] <= stat_cnt[i*STAT_W +: STAT_W] + 1'b1;
            if (any_valid && bus.wfull && stat_stall != '1)
                stat_stall <= stat_stall + 1'b1;
        end
    end
`endif
endmodule
